// File: rtl/dct_transpose_buffer.sv
// ---------------------------------------------------------------------------
// dct_transpose_buffer
//
// Transpose memory that sits between the row pass and the column pass of an
// 8x8 2-D DCT. One 8-word row is written per transfer. The same 8x8 block is
// then read back one column per transfer. There are two ping-pong banks, so
// one block can fill while the other drains. Data words are opaque and are
// never modified.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   en         global enable; when low, all state is frozen and in_ready=0
//   in_valid   row words i0..i7 are valid (ik = column k of the row)
//   in_ready   buffer can accept a row this cycle
//   i0..i7     row words, DW bits each
//   out_valid  column words o0..o7 are valid (ok = row k of the column)
//   out_ready  downstream accepts the column this cycle
//   o0..o7     column words, DW bits each; zero while out_valid=0
//   col_idx    index of the column currently presented
//   col_last   high with out_valid on column 7
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (and, on the read side, en is high). valid never depends
// combinationally on ready. in_ready depends only on en and registers.
// out_valid depends only on registers. A row presented while in_ready=0 must
// be held by the sender.
// ---------------------------------------------------------------------------
module dct_transpose_buffer #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  input  logic [DW-1:0] i2,
  input  logic [DW-1:0] i3,
  input  logic [DW-1:0] i4,
  input  logic [DW-1:0] i5,
  input  logic [DW-1:0] i6,
  input  logic [DW-1:0] i7,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] o0,
  output logic [DW-1:0] o1,
  output logic [DW-1:0] o2,
  output logic [DW-1:0] o3,
  output logic [DW-1:0] o4,
  output logic [DW-1:0] o5,
  output logic [DW-1:0] o6,
  output logic [DW-1:0] o7,
  output logic [2:0]    col_idx,
  output logic          col_last
);

  logic          wbank;
  logic          rbank;
  logic [2:0]    wrow;
  logic [2:0]    rcol;
  logic [1:0]    full;
  logic          wr_fire;
  logic          rd_fire;
  logic [DW-1:0] row_in   [0:7];
  logic [DW-1:0] col_word [0:7];

  // Block storage: bank, row, column. It is not reset. Stale words can never
  // reach the outputs, because a bank is only read while its full bit is set.
  logic [DW-1:0] mem [0:1][0:7][0:7];

  assign row_in[0] = i0;
  assign row_in[1] = i1;
  assign row_in[2] = i2;
  assign row_in[3] = i3;
  assign row_in[4] = i4;
  assign row_in[5] = i5;
  assign row_in[6] = i6;
  assign row_in[7] = i7;

  assign in_ready  = en & ~full[wbank];
  assign out_valid = full[rbank];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready & en;
  assign col_idx   = rcol;
  assign col_last  = out_valid & (rcol == 3'd7);

  // A write needs full[wbank]=0 and a read needs full[rbank]=1. The two
  // updates below therefore always touch different bits of full.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbank <= 1'b0;
      wrow  <= 3'd0;
      rbank <= 1'b0;
      rcol  <= 3'd0;
      full  <= 2'b00;
    end else begin
      if (wr_fire) begin
        if (wrow == 3'd7) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
          wrow        <= 3'd0;
        end else begin
          wrow <= wrow + 3'd1;
        end
      end
      if (rd_fire) begin
        if (rcol == 3'd7) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
          rcol        <= 3'd0;
        end else begin
          rcol <= rcol + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int k = 0; k < 8; k++) begin
        mem[wbank][wrow][k] <= row_in[k];
      end
    end
  end

  // Column read: word k of the presented column is row k of the read bank.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      col_word[k] = '0;
      if (out_valid) begin
        col_word[k] = mem[rbank][k][rcol];
      end
    end
  end

  assign o0 = col_word[0];
  assign o1 = col_word[1];
  assign o2 = col_word[2];
  assign o3 = col_word[3];
  assign o4 = col_word[4];
  assign o5 = col_word[5];
  assign o6 = col_word[6];
  assign o7 = col_word[7];

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// ---------------------------------------------------------------------------
// tb_dct_transpose_buffer
//
// Directed bench for dct_transpose_buffer. The reference model is a queue of
// whole expected columns. Each accepted row goes into a partial block. A
// completed block pushes its 8 transposed columns onto the queue. Every
// expected output is derived from the queue contents:
//   - the number of banks holding data is ceil(size/8);
//   - the number of columns already taken from the head block is
//     (8 - size%8) % 8.
// A negedge compare process checks every output against the model on every
// cycle. Hand-written literal values pin key points of the model.
// ---------------------------------------------------------------------------
module tb_dct_transpose_buffer;

  localparam int DW = 32;
  localparam int W  = 8 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    col_idx;
  logic          col_last;
  logic [DW-1:0] iv [8];
  logic [DW-1:0] i0, i1, i2, i3, i4, i5, i6, i7;
  logic [DW-1:0] o0, o1, o2, o3, o4, o5, o6, o7;

  assign i0 = iv[0];
  assign i1 = iv[1];
  assign i2 = iv[2];
  assign i3 = iv[3];
  assign i4 = iv[4];
  assign i5 = iv[5];
  assign i6 = iv[6];
  assign i7 = iv[7];

  dct_transpose_buffer #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i0        (i0),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .i4        (i4),
    .i5        (i5),
    .i6        (i6),
    .i7        (i7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .o4        (o4),
    .o5        (o5),
    .o6        (o6),
    .o7        (o7),
    .col_idx   (col_idx),
    .col_last  (col_last)
  );

  // ---------------- scoreboard ----------------
  int            tests = 0;
  int            fails = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] part [8][8];
  int            part_rows = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [W-1:0] outs();
    return {o7, o6, o5, o4, o3, o2, o1, o0};
  endfunction

  int           m_sz;
  int           m_nblk;
  int           m_cons;
  logic         m_ir;
  logic         m_ov;
  logic [W-1:0] m_data;
  logic [W-1:0] m_col;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      part_rows = 0;
    end else begin
      m_sz   = exp_q.size();
      m_nblk = (m_sz + 7) / 8;
      m_cons = (8 - (m_sz % 8)) % 8;
      m_ir   = en && (m_nblk < 2);
      m_ov   = (m_nblk > 0);
      m_data = '0;
      if (m_ov) m_data = exp_q[0];
      chk("in_ready",  W'(in_ready),  W'(m_ir));
      chk("out_valid", W'(out_valid), W'(m_ov));
      chk("col_idx",   W'(col_idx),   W'(m_cons));
      chk("col_last",  W'(col_last),  W'(m_ov && (m_cons == 7)));
      chk("col_data",  outs(),        m_data);
      // Advance the model by what the coming rising edge accepts.
      if (m_ov && out_ready && en) void'(exp_q.pop_front());
      if (in_valid && m_ir) begin
        for (int k = 0; k < 8; k++) part[part_rows][k] = iv[k];
        part_rows++;
        if (part_rows == 8) begin
          for (int c = 0; c < 8; c++) begin
            m_col = '0;
            for (int k = 0; k < 8; k++) m_col[k*DW +: DW] = part[k][c];
            exp_q.push_back(m_col);
          end
          part_rows = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one row (ik = base + 16*r + k) and hold it until it is accepted.
  task automatic drive_row(input logic [DW-1:0] base, input int r, output int stalls);
    for (int k = 0; k < 8; k++) iv[k] = base + DW'(16 * r + k);
    in_valid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!in_ready) begin
      stalls++;
      if (stalls > 200) begin
        tests++;
        fails++;
        $display("FAIL row_accept_timeout: row %0d never accepted", r);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_block(input logic [DW-1:0] base, output int stall_total);
    int st;
    stall_total = 0;
    for (int r = 0; r < 8; r++) begin
      drive_row(base, r, st);
      stall_total += st;
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      n++;
      if (n > 300) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: %0d columns left", exp_q.size());
        break;
      end
      step(1);
    end
    step(1);
  endtask

  // ---------------- directed stimulus ----------------
  int           st;
  int           tot;
  logic [W-1:0] lit;

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) iv[k] = '0;
    step(2);
    reset = 1'b0;
    en    = 1'b1;

    // Reset / idle
    step(3);
    chk("idle_in_ready",  W'(in_ready),  W'(1));
    chk("idle_out_valid", W'(out_valid), W'(0));
    chk("idle_data",      outs(),        '0);
    chk("idle_col_idx",   W'(col_idx),   W'(0));

    // Single block transpose, ik = 16*r + k
    drive_block('0, tot);
    in_valid = 1'b0;
    chk("lat_out_valid", W'(out_valid), W'(1));
    lit = {32'd112, 32'd96, 32'd80, 32'd64, 32'd48, 32'd32, 32'd16, 32'd0};
    chk("lat_col0_data", outs(), lit);
    out_ready = 1'b1;
    step(3);
    out_ready = 1'b0;
    chk("col3_idx", W'(col_idx), W'(3));
    lit = {32'd115, 32'd99, 32'd83, 32'd67, 32'd51, 32'd35, 32'd19, 32'd3};
    chk("col3_data", outs(), lit);
    chk("col3_last", W'(col_last), W'(0));
    out_ready = 1'b1;
    step(4);
    chk("col7_last", W'(col_last), W'(1));
    step(1);
    chk("single_done_valid", W'(out_valid), W'(0));

    // Back-to-back: 3 blocks, out_ready held high
    tot = 0;
    for (int b = 0; b < 3; b++) begin
      drive_block(DW'(32'h1000 * (b + 1)), st);
      tot += st;
    end
    in_valid = 1'b0;
    chk("b2b_stalls", W'(tot), W'(0));
    wait_empty();

    // Backpressure: 16 rows fill both banks, the 17th is held
    out_ready = 1'b0;
    drive_block(32'h5000, st);
    drive_block(32'h6000, tot);
    tot += st;
    chk("bp_fill_stalls", W'(tot), W'(0));
    for (int k = 0; k < 8; k++) iv[k] = 32'h7000 + DW'(k);
    in_valid = 1'b1;
    step(3);
    chk("bp_in_ready", W'(in_ready), W'(0));
    out_ready = 1'b1;
    drive_row(32'h7000, 0, st);
    chk("bp_hold_cycles", W'(st), W'(8));
    for (int r = 1; r < 8; r++) drive_row(32'h7000, r, st);
    in_valid = 1'b0;
    wait_empty();

    // Enable freeze at column 4
    out_ready = 1'b0;
    drive_block(32'h8000, st);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(4);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("frz_col_idx",  W'(col_idx),  W'(4));
      chk("frz_in_ready", W'(in_ready), W'(0));
    end
    en = 1'b1;
    wait_empty();

    // Reset mid-fill (row 5 of block 2) and mid-drain (block 1 at column 2)
    out_ready = 1'b0;
    drive_block(32'h9000, st);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(2);
    out_ready = 1'b0;
    for (int r = 0; r < 6; r++) drive_row(32'hA000, r, st);
    in_valid = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_col_idx",   W'(col_idx),   W'(0));
    out_ready = 1'b1;
    drive_block(32'hB000, st);
    in_valid = 1'b0;
    wait_empty();
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
